rr_arbiter_4way: RTL and testbench

- Four-requester round-robin arbiter that shares one resource (a bus or register-file port) between four clients.
- Produces a registered one-hot grant plus its 2-bit encoded index, suitable for steering the downstream mux/select decode.
- Enforces fairness by rotating priority, and caps each client's tenure at MAX_HOLD cycles while others are waiting.

---
 rtl/rr_arbiter_4way_pkg.sv | 23 ++
 rtl/rr_arbiter_4way_picker.sv | 30 +++
 rtl/rr_arbiter_4way.sv | 94 +++++++++
 tb/tb_rr_arbiter_4way.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4way_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM states,
// reset pointer and a one-hot decode helper.
package rr_arb_defs;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Pointer starts at the last client so client 0 has first priority.
    localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_4way_picker.sv
// Circular priority search: first unmasked requester at or after 'start',
// wrapping around all four positions.
module rr_priority_picker
    import rr_arb_defs::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic [NUM_REQ-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pos;

    always_comb begin
        cand  = req & ~mask;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = start + IDX_W'(k);
            if (!found && cand[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4way.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded
// owner index, and a tenure cap of MAX_HOLD cycles while others wait.
module rr_arbiter_4way
    import rr_arb_defs::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid
);

    state_t             state_q, state_nx;
    logic [IDX_W-1:0]   last_q, last_nx;
    logic [IDX_W-1:0]   id_q, id_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_mask;

    // While granting, the owner is excluded so handover and preemption both
    // land on the next other requester after it; when idle nobody is masked.
    assign pick_mask = (state_q == GRANT) ? onehot(id_q) : '0;

    rr_priority_picker u_picker (
        .req   (req),
        .start (last_q + 2'd1),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= PTR_RST;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            last_q  <= last_nx;
            id_q    <= id_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        last_nx  = last_q;
        id_nx    = id_q;
        cnt_nx   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_nx = GRANT;
                    last_nx  = pick_idx;
                    id_nx    = pick_idx;
                    cnt_nx   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[id_q]) begin
                    if (pick_found) begin
                        last_nx = pick_idx;
                        id_nx   = pick_idx;
                        cnt_nx  = CNT_W'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (cnt_q == CNT_W'(MAX_HOLD) && pick_found) begin
                    last_nx = pick_idx;
                    id_nx   = pick_idx;
                    cnt_nx  = CNT_W'(1);
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid = (state_q == GRANT);
        gnt_id    = id_q;
        gnt       = gnt_valid ? onehot(id_q) : '0;
    end

endmodule

// File: tb/tb_rr_arbiter_4way.sv
// Scoreboard bench: two arbiters (MAX_HOLD=8 and MAX_HOLD=1) share one request
// stream; a behavioural model predicts each cycle's grant into per-DUT queues.
module tb_rr_arbiter_4way;

    localparam int MH0 = 8;
    localparam int MH1 = 1;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt0, gnt1;
    logic [1:0] id0, id1;
    logic       v0, v1;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;

    int own[2];
    int ptr[2];
    int mid[2];
    int cnt[2];
    int wt[2][4];

    rr_arbiter_4way #(.MAX_HOLD(MH0), .CNT_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0)
    );

    rr_arbiter_4way #(.MAX_HOLD(MH1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1)
    );

    always #5 clk = ~clk;

    // Reference: owner as an integer (-1 = idle), pointer and tenure count.
    task automatic model_step(input int n, input logic [3:0] r, input logic rn, output exp_t e);
        int mh;
        int w;
        mh = (n == 0) ? MH0 : MH1;
        w  = -1;
        if (!rn) begin
            own[n] = -1; ptr[n] = 3; mid[n] = 0; cnt[n] = 0;
        end else if (own[n] < 0) begin
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(ptr[n] + k) % 4]) w = (ptr[n] + k) % 4;
            if (w >= 0) begin
                own[n] = w; ptr[n] = w; mid[n] = w; cnt[n] = 1;
            end
        end else begin
            for (int k = 1; k <= 3; k++)
                if (w < 0 && r[(own[n] + k) % 4]) w = (own[n] + k) % 4;
            if (!r[own[n]]) begin
                if (w >= 0) begin
                    own[n] = w; ptr[n] = w; mid[n] = w; cnt[n] = 1;
                end else begin
                    own[n] = -1;
                end
            end else if (cnt[n] == mh && w >= 0) begin
                own[n] = w; ptr[n] = w; mid[n] = w; cnt[n] = 1;
            end else if (cnt[n] < mh) begin
                cnt[n] = cnt[n] + 1;
            end
        end
        e.g  = (own[n] >= 0) ? 4'(1 << own[n]) : 4'b0000;
        e.id = 2'(mid[n]);
        e.v  = (own[n] >= 0);
    endtask

    task automatic drive(input logic [3:0] r, input logic rn, input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            req = r;
            reset_n = rn;
            model_step(0, r, rn, e); q0.push_back(e);
            model_step(1, r, rn, e); q1.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_dut(input int n, input logic [3:0] g, input logic [1:0] id, input logic v);
        exp_t e;
        logic ok;
        int lim;
        lim = 3 * ((n == 0) ? MH0 : MH1) + 1;
        if (n == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            chk("dut0_out{gnt,id,valid}", {g, id, v}, e);
        end
        if (n == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut1_out{gnt,id,valid}", {g, id, v}, e);
        end
        ok = $onehot0(g) && (v == |g) && (!v || g == (4'b0001 << id));
        chk(n == 0 ? "dut0_invariant" : "dut1_invariant", 7'(ok), 7'd1);
        for (int i = 0; i < 4; i++) begin
            if (!reset_n || !req[i] || g[i]) wt[n][i] = 0;
            else wt[n][i] = wt[n][i] + 1;
            if (wt[n][i] > lim) begin
                chk(n == 0 ? "dut0_wait_bound" : "dut1_wait_bound", 7'(wt[n][i]), 7'(lim));
                wt[n][i] = 0;
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 4; i++) wt[n][i] = 0;
        forever begin
            @(posedge clk);
            #1;
            check_dut(0, gnt0, id0, v0);
            check_dut(1, gnt1, id1, v1);
        end
    end

    initial begin
        logic [3:0] r;
        logic       rn;
        for (int n = 0; n < 2; n++) begin
            own[n] = -1; ptr[n] = 3; mid[n] = 0; cnt[n] = 0;
        end
        drive(4'b0000, 1'b0, 2);
        drive(4'b0101, 1'b1, 3);
        drive(4'b0100, 1'b1, 3);
        drive(4'b0000, 1'b1, 2);
        drive(4'b1111, 1'b1, 40);
        drive(4'b0000, 1'b1, 2);
        drive(4'b0100, 1'b1, 20);
        drive(4'b0110, 1'b1, 3);
        drive(4'b1000, 1'b1, 3);
        drive(4'b0000, 1'b1, 2);
        drive(4'b1001, 1'b1, 3);
        drive(4'b0010, 1'b1, 3);
        drive(4'b0010, 1'b0, 1);
        drive(4'b1110, 1'b1, 3);
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            rn = ($urandom_range(0, 499) != 0);
            drive(r, rn, 1);
        end
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
